// File: rtl/memory2_pkg.sv
// Shared CPU definitions used by the memory2 stage: pipeline pass structs,
// load-type encoding and the memory2 load-tracking FSM states.
package cpu_defs;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Load width/sign selector carried down the pipe with each load.
    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_BU = 3'd1,
        LD_H  = 3'd2,
        LD_HU = 3'd3,
        LD_W  = 3'd4
    } ld_type_t;

    // Load-response tracking inside memory2.
    //   IDLE  : no load response pending
    //   WAIT  : load held, data not yet returned
    //   HOLD  : data returned and buffered while writeback stalls
    //   DRAIN : held load was flushed, its response is still owed
    typedef enum logic [1:0] {
        M2_IDLE  = 2'd0,
        M2_WAIT  = 2'd1,
        M2_HOLD  = 2'd2,
        M2_DRAIN = 2'd3
    } m2_state_t;

    typedef struct packed {
        logic              valid;
        logic              is_ld;
        ld_type_t          ld_type;
        logic [1:0]        va;
        logic [REG_AW-1:0] rd;
        logic              is_wr_rd;
        logic [XLEN-1:0]   ex_out;
    } memory1_memory2_pass_t;

    typedef struct packed {
        logic              valid;
        logic              is_ld;
        logic [REG_AW-1:0] rd;
        logic              is_wr_rd;
        logic [XLEN-1:0]   ex_mem_out;
    } memory2_writeback_pass_t;

    // True for load types whose result is sign-extended.
    function automatic logic is_signed_load(ld_type_t t);
        return (t == LD_B) || (t == LD_H);
    endfunction

endpackage

// File: rtl/memory2_if.sv
// Bundle of memory2 stage signals: upstream pass/ready, downstream
// pass/ready, dcache load response, decode bypass and FSM debug state.
//
// Handshake: the stage consumes pass_in on every clock edge where rdy_in is
// high (pass_in.valid marks whether it carries an instruction); pass_out is
// consumed by writeback on every edge where pass_out.valid is high, which
// the stage only raises while next_rdy_in is high.
interface memory2_if;
    import cpu_defs::*;

    logic                    flush;
    logic                    next_rdy_in;
    logic                    rdy_in;
    memory1_memory2_pass_t   pass_in;
    logic                    dc_rdata_valid;
    logic [XLEN-1:0]         dc_rdata;
    memory2_writeback_pass_t pass_out;
    logic                    fwd_valid;
    logic [REG_AW-1:0]       fwd_rd;
    logic [XLEN-1:0]         fwd_data;
    m2_state_t               state;

    modport master (
        output flush, next_rdy_in, pass_in, dc_rdata_valid, dc_rdata,
        input  rdy_in, pass_out, fwd_valid, fwd_rd, fwd_data, state
    );

    modport slave (
        input  flush, next_rdy_in, pass_in, dc_rdata_valid, dc_rdata,
        output rdy_in, pass_out, fwd_valid, fwd_rd, fwd_data, state
    );

endinterface

// File: rtl/memory2_load_align.sv
// Combinational load alignment: selects the addressed byte/half of the
// raw aligned word and sign- or zero-extends it to 32 bits.
module load_align
    import cpu_defs::*;
(
    input  ld_type_t        ld_type,
    input  logic [1:0]      va,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_bit;

    // Lane select, then extension; halves ignore va[0], words ignore va.
    always_comb begin
        byte_sel = word[{va, 3'b000} +: 8];
        half_sel = word[{va[1], 4'b0000} +: 16];
        sign_bit = 1'b0;
        result   = word;
        case (ld_type)
            LD_B, LD_BU: begin
                sign_bit = is_signed_load(ld_type) & byte_sel[7];
                result   = {{24{sign_bit}}, byte_sel};
            end
            LD_H, LD_HU: begin
                sign_bit = is_signed_load(ld_type) & half_sel[15];
                result   = {{16{sign_bit}}, half_sel};
            end
            default: result = word;
        endcase
    end

endmodule

// File: rtl/memory2.sv
// Memory2 pipeline stage: holds one instruction from memory1, waits for the
// dcache response of a held load, aligns it and passes the result to
// writeback. Responses owed to flushed loads are drained so that a later
// load never consumes a stale response.
module memory2
    import cpu_defs::*;
(
    input logic      clk,
    input logic      rst_n,
    memory2_if.slave bus
);

    memory1_memory2_pass_t held;
    m2_state_t             state;
    m2_state_t             state_nxt;
    logic [XLEN-1:0]       data_buf;
    logic                  buf_load;

    logic                  held_ld;
    logic                  have_data;
    logic                  waiting;
    logic                  m2_flush;
    logic                  m2_stall;
    logic                  rdy;
    logic                  next_held_ld;
    logic [XLEN-1:0]       load_word;
    logic [XLEN-1:0]       load_result;
    logic [XLEN-1:0]       result;

    assign held_ld   = held.valid & held.is_ld;
    // Data is available either straight off the dcache in WAIT or from the
    // buffer in HOLD; in DRAIN the arriving response belongs to a dead load.
    assign have_data = ((state == M2_WAIT) & bus.dc_rdata_valid) | (state == M2_HOLD);
    assign waiting   = held.is_ld & ~have_data;

    assign m2_flush  = bus.flush | ~held.valid;
    assign m2_stall  = ~bus.next_rdy_in | (held_ld & ~have_data);
    assign rdy       = m2_flush | ~m2_stall;

    // Whether the register will hold a live load after this edge.
    assign next_held_ld = rdy ? (bus.pass_in.valid & bus.pass_in.is_ld) : held_ld;

    // Input register: capture on rdy, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
        end else if (rdy) begin
            held <= bus.pass_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= M2_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and buffer-load strobe.
    always_comb begin
        state_nxt = state;
        buf_load  = 1'b0;
        case (state)
            M2_IDLE: begin
                if (next_held_ld) begin
                    state_nxt = M2_WAIT;
                end
            end
            M2_WAIT: begin
                if (bus.dc_rdata_valid) begin
                    // Emitted this cycle (bypass) or discarded by flush.
                    if (bus.flush || bus.next_rdy_in) begin
                        state_nxt = next_held_ld ? M2_WAIT : M2_IDLE;
                    end else begin
                        state_nxt = M2_HOLD;
                        buf_load  = 1'b1;
                    end
                end else if (bus.flush) begin
                    // The killed load's response is still on its way.
                    state_nxt = M2_DRAIN;
                end
            end
            M2_HOLD: begin
                if (bus.flush || bus.next_rdy_in) begin
                    state_nxt = next_held_ld ? M2_WAIT : M2_IDLE;
                end
            end
            M2_DRAIN: begin
                // First response is the dead one; a load captured meanwhile
                // waits for the following response.
                if (bus.dc_rdata_valid) begin
                    state_nxt = next_held_ld ? M2_WAIT : M2_IDLE;
                end
            end
            default: state_nxt = M2_IDLE;
        endcase
    end

    // Response buffer for writeback stalls; contents only matter in HOLD.
    always_ff @(posedge clk) begin
        if (buf_load) begin
            data_buf <= bus.dc_rdata;
        end
    end

    assign load_word = (state == M2_HOLD) ? data_buf : bus.dc_rdata;

    load_align u_load_align (
        .ld_type (held.ld_type),
        .va      (held.va),
        .word    (load_word),
        .result  (load_result)
    );

    assign result = held.is_ld ? load_result : held.ex_out;

    // Stage outputs: writeback pass, bypass and debug state.
    always_comb begin
        bus.pass_out.valid      = ~m2_flush & ~m2_stall;
        bus.pass_out.is_ld      = held.is_ld;
        bus.pass_out.rd         = held.rd;
        bus.pass_out.is_wr_rd   = held.is_wr_rd;
        bus.pass_out.ex_mem_out = result;
        bus.rdy_in              = rdy;
        bus.fwd_valid           = held.valid & held.is_wr_rd & ~waiting;
        bus.fwd_rd              = held.rd;
        bus.fwd_data            = result;
        bus.state               = state;
    end

endmodule

// File: tb/tb_memory2.sv
// Bench for memory2: directed scenarios with literal expectations followed
// by randomized traffic, all checked every cycle against a behavioural model
// that tracks the held instruction, its data and the count of dead responses.
module tb_memory2;
    import cpu_defs::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory2_if bus();

    memory2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard / model state ----------------
    int checks   = 0;
    int failures = 0;
    int hits     = 0;

    logic [31:0]           exp_q[$];
    memory1_memory2_pass_t m_held;
    logic                  m_have;
    logic [31:0]           m_buf;
    int                    m_dead;

    logic                  exp_rdy;
    logic                  exp_valid;
    logic                  exp_fwd;
    logic                  arrive;
    logic [31:0]           exp_data;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check_bit(string name, logic act, logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
        end
    endtask

    // Reference extraction by plain arithmetic on the word value.
    function automatic logic [31:0] ref_align(ld_type_t t, logic [1:0] va, logic [31:0] w);
        int unsigned v;
        case (t)
            LD_B, LD_BU: begin
                v = (w >> (8 * int'(va))) % 256;
                if (t == LD_B && v >= 128) return v - 256;
                return v;
            end
            LD_H, LD_HU: begin
                v = (w >> (16 * int'(va[1]))) % 65536;
                if (t == LD_H && v >= 32768) return v - 65536;
                return v;
            end
            default: return w;
        endcase
    endfunction

    function automatic memory1_memory2_pass_t mk_pass(logic v, logic ld, ld_type_t t,
                                                      logic [1:0] va, logic [4:0] rd,
                                                      logic wr, logic [31:0] ex);
        memory1_memory2_pass_t p;
        p.valid    = v;
        p.is_ld    = ld;
        p.ld_type  = t;
        p.va       = va;
        p.rd       = rd;
        p.is_wr_rd = wr;
        p.ex_out   = ex;
        return p;
    endfunction

    task automatic model_reset();
        m_held = '0;
        m_have = 1'b0;
        m_dead = 0;
        exp_q.delete();
    endtask

    // Expected outputs for the current inputs and model state.
    task automatic eval_model();
        logic ld_held, have, stall, kill;
        logic [31:0] word;
        ld_held   = m_held.valid && m_held.is_ld;
        arrive    = bus.dc_rdata_valid && (m_dead == 0) && ld_held && !m_have;
        have      = m_have || arrive;
        word      = m_have ? m_buf : bus.dc_rdata;
        stall     = !bus.next_rdy_in || (ld_held && !have);
        kill      = bus.flush || !m_held.valid;
        exp_rdy   = kill || !stall;
        exp_valid = !kill && !stall;
        exp_data  = m_held.is_ld ? ref_align(m_held.ld_type, m_held.va, word) : m_held.ex_out;
        exp_fwd   = m_held.valid && m_held.is_wr_rd && !(m_held.is_ld && !have);
    endtask

    task automatic compare();
        check_bit("rdy_in", bus.rdy_in, exp_rdy);
        check_bit("pass_out.valid", bus.pass_out.valid, exp_valid);
        check_bit("fwd_valid", bus.fwd_valid, exp_fwd);
        if (exp_valid) begin
            exp_q.push_back(exp_data);
            check("pass_out.rd", 32'(bus.pass_out.rd), 32'(m_held.rd));
            check_bit("pass_out.is_wr_rd", bus.pass_out.is_wr_rd, m_held.is_wr_rd);
        end
        if (bus.pass_out.valid) begin
            if (exp_q.size() == 0) begin
                check_bit("pass_out.unexpected", 1'b1, 1'b0);
            end else begin
                check("pass_out.ex_mem_out", bus.pass_out.ex_mem_out, exp_q.pop_front());
            end
        end
        exp_q.delete();
        if (exp_fwd) begin
            check("fwd_rd", 32'(bus.fwd_rd), 32'(m_held.rd));
            check("fwd_data", bus.fwd_data, exp_data);
        end
    endtask

    // Advance the model across a clock edge using this cycle's inputs.
    task automatic update_model();
        logic ld_held, have;
        ld_held = m_held.valid && m_held.is_ld;
        have    = m_have || arrive;
        if (bus.dc_rdata_valid && m_dead > 0) m_dead--;
        if (exp_rdy) begin
            if (bus.flush && ld_held && !have) m_dead++;
            m_held = bus.pass_in;
            m_have = 1'b0;
        end else if (arrive) begin
            m_have = 1'b1;
            m_buf  = bus.dc_rdata;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(logic fl, logic nr, memory1_memory2_pass_t pin, logic dv, logic [31:0] d);
        bus.flush          = fl;
        bus.next_rdy_in    = nr;
        bus.pass_in        = pin;
        bus.dc_rdata_valid = dv;
        bus.dc_rdata       = d;
    endtask

    task automatic sample();
        @(negedge clk);
        eval_model();
        compare();
        if (bus.pass_out.valid && bus.pass_out.ex_mem_out == 32'h2222_2222) hits++;
    endtask

    task automatic advance();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic cycle(logic fl, logic nr, memory1_memory2_pass_t pin, logic dv, logic [31:0] d);
        drive(fl, nr, pin, dv, d);
        sample();
        advance();
    endtask

    task automatic random_cycle();
        memory1_memory2_pass_t pin;
        logic ld_held, owed, allow_fl, fl, dv, nr;
        ld_held      = m_held.valid && m_held.is_ld;
        owed         = (m_dead > 0) || (ld_held && !m_have);
        allow_fl     = !(m_dead > 0 && ld_held && !m_have);
        fl           = allow_fl && ($urandom_range(0, 7) == 0);
        dv           = owed && ($urandom_range(0, 1) == 1);
        nr           = ($urandom_range(0, 3) != 0);
        pin.valid    = ($urandom_range(0, 3) != 0);
        pin.is_ld    = ($urandom_range(0, 1) == 1);
        pin.ld_type  = ld_type_t'(3'($urandom_range(0, 4)));
        pin.va       = 2'($urandom_range(0, 3));
        pin.rd       = 5'($urandom());
        pin.is_wr_rd = ($urandom_range(0, 1) == 1);
        pin.ex_out   = $urandom();
        cycle(fl, nr, pin, dv, $urandom());
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    memory1_memory2_pass_t idle;

    initial begin
        idle = mk_pass(1'b0, 1'b0, LD_W, 2'd0, 5'd0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, idle, 1'b0, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("reset rdy_in", bus.rdy_in, 1'b1);
        check_bit("reset pass_out.valid", bus.pass_out.valid, 1'b0);
        check_bit("reset fwd_valid", bus.fwd_valid, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Signed byte load, result on the data-valid cycle.
        cycle(1'b0, 1'b1, mk_pass(1'b1, 1'b1, LD_B, 2'd3, 5'd5, 1'b1, 32'd0), 1'b0, 32'd0);
        cycle(1'b0, 1'b1, idle, 1'b0, 32'd0);
        drive(1'b0, 1'b1, idle, 1'b1, 32'h80AA_BBCC);
        sample();
        check_bit("ldb valid", bus.pass_out.valid, 1'b1);
        check("ldb data", bus.pass_out.ex_mem_out, 32'hFFFF_FF80);
        advance();

        // Unsigned half load buffered while writeback stalls.
        cycle(1'b0, 1'b1, mk_pass(1'b1, 1'b1, LD_HU, 2'd2, 5'd7, 1'b1, 32'd0), 1'b0, 32'd0);
        drive(1'b0, 1'b0, idle, 1'b1, 32'h9234_5678);
        sample();
        check_bit("ldhu data-cycle rdy_in", bus.rdy_in, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, idle, 1'b0, 32'd0);
            sample();
            check("ldhu state", 32'(bus.state), 32'(M2_HOLD));
            check_bit("ldhu hold rdy_in", bus.rdy_in, 1'b0);
            check_bit("ldhu hold valid", bus.pass_out.valid, 1'b0);
            advance();
        end
        drive(1'b0, 1'b1, idle, 1'b0, 32'd0);
        sample();
        check_bit("ldhu valid", bus.pass_out.valid, 1'b1);
        check("ldhu data", bus.pass_out.ex_mem_out, 32'h0000_9234);
        advance();

        // Flush in WAIT, next load captured, stale response drained.
        cycle(1'b0, 1'b1, mk_pass(1'b1, 1'b1, LD_W, 2'd0, 5'd9, 1'b1, 32'd0), 1'b0, 32'd0);
        cycle(1'b1, 1'b1, mk_pass(1'b1, 1'b1, LD_W, 2'd0, 5'd10, 1'b1, 32'd0), 1'b0, 32'd0);
        drive(1'b0, 1'b1, idle, 1'b0, 32'd0);
        sample();
        check("drain state", 32'(bus.state), 32'(M2_DRAIN));
        advance();
        hits = 0;
        drive(1'b0, 1'b1, idle, 1'b1, 32'h1111_1111);
        sample();
        check_bit("stale valid", bus.pass_out.valid, 1'b0);
        advance();
        cycle(1'b0, 1'b1, idle, 1'b1, 32'h2222_2222);
        repeat (3) cycle(1'b0, 1'b1, idle, 1'b0, 32'd0);
        check("fresh data count", 32'(hits), 32'd1);

        // Non-load instruction passes through and forwards.
        cycle(1'b0, 1'b1, mk_pass(1'b1, 1'b0, LD_W, 2'd0, 5'd3, 1'b1, 32'h5), 1'b0, 32'd0);
        drive(1'b0, 1'b1, idle, 1'b0, 32'd0);
        sample();
        check_bit("add valid", bus.pass_out.valid, 1'b1);
        check("add data", bus.pass_out.ex_mem_out, 32'h5);
        check_bit("add fwd_valid", bus.fwd_valid, 1'b1);
        check("add fwd_data", bus.fwd_data, 32'h5);
        advance();

        // Asynchronous reset in the middle of WAIT.
        cycle(1'b0, 1'b1, mk_pass(1'b1, 1'b1, LD_W, 2'd0, 5'd4, 1'b1, 32'd0), 1'b0, 32'd0);
        drive(1'b0, 1'b1, idle, 1'b0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_bit("async rst rdy_in", bus.rdy_in, 1'b1);
        check_bit("async rst valid", bus.pass_out.valid, 1'b0);
        check_bit("async rst fwd_valid", bus.fwd_valid, 1'b0);
        check("async rst state", 32'(bus.state), 32'(M2_IDLE));
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1'b0, 1'b1, mk_pass(1'b1, 1'b1, LD_W, 2'd1, 5'd4, 1'b1, 32'd0), 1'b0, 32'd0);
        drive(1'b0, 1'b1, idle, 1'b1, 32'hCAFE_F00D);
        sample();
        check_bit("post-rst valid", bus.pass_out.valid, 1'b1);
        check("post-rst data", bus.pass_out.ex_mem_out, 32'hCAFE_F00D);
        advance();

        // Model self-pins on the reference extraction.
        check("ref lb", ref_align(LD_B, 2'd1, 32'h0000_FF00), 32'hFFFF_FFFF);
        check("ref lbu", ref_align(LD_BU, 2'd2, 32'h0080_0000), 32'h0000_0080);
        check("ref lh", ref_align(LD_H, 2'd3, 32'h8001_0000), 32'hFFFF_8001);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            random_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
